// File: rtl/reg_bank_pkg.sv
// Shared types and width helpers for the register bank.
// Imported by the bank top and its byte-merge sub-module.
package reg_bank_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StClear = 1'b1
    } state_e;

    localparam int unsigned BYTE_W = 8;

    // Index width for a bank of nregs entries; never below one bit.
    function automatic int unsigned addr_w(input int unsigned nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    // Number of byte lanes covered by the write enables.
    function automatic int unsigned be_w(input int unsigned data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/reg_bank_be_merge.sv
// Combinational byte-enable merge: lanes with be_i set take new_i, the rest keep old_i.
// Shared by the write path and both read-bypass paths.
module be_merge
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]         old_i,
    input  logic [DATA_W-1:0]         new_i,
    input  logic [be_w(DATA_W)-1:0]   be_i,
    output logic [DATA_W-1:0]         merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < int'(be_w(DATA_W)); i++) begin
            if (be_i[i]) begin
                merged_o[i*BYTE_W +: BYTE_W] = new_i[i*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/reg_bank.sv
// Architectural register file: one byte-masked write port, two bypassed read ports,
// optional hardwired-zero register 0 and a one-register-per-cycle bulk-clear sequencer.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NREGS    = 16,
    parameter int unsigned ADDR_W   = addr_w(NREGS),
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [be_w(DATA_W)-1:0]   wr_be,
    input  logic [ADDR_W-1:0]         rd_addr_a,
    input  logic [ADDR_W-1:0]         rd_addr_b,
    output logic [DATA_W-1:0]         rd_data_a,
    output logic [DATA_W-1:0]         rd_data_b,
    input  logic                      clr_req,
    output logic                      busy
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   regs_d [NREGS];

    logic                wr_fire;
    logic                wr_zero;
    logic [DATA_W-1:0]   wr_merged;
    logic [DATA_W-1:0]   byp_a;
    logic [DATA_W-1:0]   byp_b;

    assign wr_fire = wr_valid && (state_q == StIdle);
    assign wr_zero = ZERO_REG && (wr_addr == '0);

    be_merge #(
        .DATA_W (DATA_W)
    ) u_wr_merge (
        .old_i    (regs_q[wr_addr]),
        .new_i    (wr_data),
        .be_i     (wr_be),
        .merged_o (wr_merged)
    );

    be_merge #(
        .DATA_W (DATA_W)
    ) u_byp_a_merge (
        .old_i    (regs_q[rd_addr_a]),
        .new_i    (wr_data),
        .be_i     (wr_be),
        .merged_o (byp_a)
    );

    be_merge #(
        .DATA_W (DATA_W)
    ) u_byp_b_merge (
        .old_i    (regs_q[rd_addr_b]),
        .new_i    (wr_data),
        .be_i     (wr_be),
        .merged_o (byp_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d   = StClear;
                    clr_idx_d = '0;
                end
            end
            StClear: begin
                clr_idx_d = clr_idx_q + ADDR_W'(1);
                if (clr_idx_q == ADDR_W'(NREGS - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ready = (state_q == StIdle);
        busy     = (state_q == StClear);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // A write and clr_req in the same idle cycle both land: the write now, the clear after.
    always_comb begin
        regs_d = regs_q;
        if (wr_fire && !wr_zero) begin
            regs_d[wr_addr] = wr_merged;
        end
        if (state_q == StClear) begin
            regs_d[clr_idx_q] = '0;
        end
    end

    always_comb begin
        if (ZERO_REG && (rd_addr_a == '0)) begin
            rd_data_a = '0;
        end else if (wr_fire && (wr_addr == rd_addr_a)) begin
            rd_data_a = byp_a;
        end else begin
            rd_data_a = regs_q[rd_addr_a];
        end

        if (ZERO_REG && (rd_addr_b == '0)) begin
            rd_data_b = '0;
        end else if (wr_fire && (wr_addr == rd_addr_b)) begin
            rd_data_b = byp_b;
        end else begin
            rd_data_b = regs_q[rd_addr_b];
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: vector table for write/bypass/zero-register behaviour,
// plus hand-written sequences for bulk clear, writes held during clear and reset mid-clear.
module tb_reg_bank;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        clr_req;
    logic        busy;

    reg_bank #(
        .DATA_W   (32),
        .NREGS    (16),
        .ZERO_REG (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .clr_req   (clr_req),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    vec_t vecs [11];
    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] be);
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        wr_be    = be;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(15 - i);
            #1;
            check($sformatf("%s_a[%0d]", tag, i), rd_data_a, 32'h0);
            check($sformatf("%s_b[%0d]", tag, 15 - i), rd_data_b, 32'h0);
        end
    endtask

    initial begin
        int   busy_cnt;
        exp_t e;

        rst       = 1'b1;
        clr_req   = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        drive(1'b0, 4'd0, 32'h0, 4'h0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("reset_wr_ready", 32'(wr_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check_all_zero("reset_rd");
        tick();

        // Write / bypass / zero-register vectors
        vecs[0]  = '{1'b1, 4'd3,  32'hDEADBEEF, 4'b1111, 4'd3,  4'd0,  32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b1, 4'd3,  32'h11223344, 4'b0101, 4'd3,  4'd3,  32'hDE22BE44, 32'hDE22BE44};
        vecs[2]  = '{1'b0, 4'd3,  32'h0,        4'b0000, 4'd3,  4'd1,  32'hDE22BE44, 32'h0};
        vecs[3]  = '{1'b1, 4'd0,  32'hFFFFFFFF, 4'b1111, 4'd0,  4'd0,  32'h0,        32'h0};
        vecs[4]  = '{1'b0, 4'd0,  32'h0,        4'b0000, 4'd0,  4'd3,  32'h0,        32'hDE22BE44};
        vecs[5]  = '{1'b1, 4'd7,  32'h12345678, 4'b1000, 4'd7,  4'd3,  32'h12000000, 32'hDE22BE44};
        vecs[6]  = '{1'b1, 4'd7,  32'hAABBCCDD, 4'b0000, 4'd7,  4'd7,  32'h12000000, 32'h12000000};
        vecs[7]  = '{1'b1, 4'd7,  32'hAABBCCDD, 4'b0010, 4'd7,  4'd15, 32'h1200CC00, 32'h0};
        vecs[8]  = '{1'b0, 4'd7,  32'h0,        4'b0000, 4'd7,  4'd0,  32'h1200CC00, 32'h0};
        vecs[9]  = '{1'b0, 4'd15, 32'hCAFEF00D, 4'b1111, 4'd15, 4'd0,  32'h0,        32'h0};
        vecs[10] = '{1'b0, 4'd0,  32'h0,        4'b0000, 4'd15, 4'd8,  32'h0,        32'h0};

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].be);
            rd_addr_a = vecs[i].ra;
            rd_addr_b = vecs[i].rb;
            sb.push_back('{$sformatf("vec%0d_rd_a", i), vecs[i].exp_a});
            sb.push_back('{$sformatf("vec%0d_rd_b", i), vecs[i].exp_b});
            @(negedge clk);
            e = sb.pop_front();
            check(e.name, rd_data_a, e.val);
            e = sb.pop_front();
            check(e.name, rd_data_b, e.val);
            check($sformatf("vec%0d_wr_ready", i), 32'(wr_ready), 32'd1);
            tick();
        end
        drive(1'b0, 4'd0, 32'h0, 4'h0);

        // Fill 1..15, then clear with a simultaneous write to reg 5
        for (int a = 1; a < 16; a++) begin
            drive(1'b1, 4'(a), 32'hA5A5A5A5, 4'hF);
            tick();
        end
        drive(1'b1, 4'd5, 32'h00000005, 4'hF);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 4'h0);
        rd_addr_a = 4'd5;
        rd_addr_b = 4'd15;
        sb.push_back('{"clr_wr_commit_reg5", 32'h00000005});
        sb.push_back('{"clr_c1_reg15", 32'hA5A5A5A5});
        @(negedge clk);
        check("clr_c1_busy", 32'(busy), 32'd1);
        check("clr_c1_wr_ready", 32'(wr_ready), 32'd0);
        e = sb.pop_front();
        check(e.name, rd_data_a, e.val);
        e = sb.pop_front();
        check(e.name, rd_data_b, e.val);
        busy_cnt  = busy ? 1 : 0;
        rd_addr_a = 4'd15;
        rd_addr_b = 4'd8;
        for (int c = 2; c <= 40; c++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cnt++;
            check($sformatf("clr_c%0d_wr_ready", c), 32'(wr_ready), 32'd0);
            if (c == 10) begin
                sb.push_back('{"clr_c10_reg15", 32'hA5A5A5A5});
                sb.push_back('{"clr_c10_reg8", 32'h0});
                e = sb.pop_front();
                check(e.name, rd_data_a, e.val);
                e = sb.pop_front();
                check(e.name, rd_data_b, e.val);
            end
        end
        check("clr_busy_cycles", 32'(busy_cnt), 32'd16);
        check("clr_done_wr_ready", 32'(wr_ready), 32'd1);
        check_all_zero("clr_done_rd");
        tick();

        // Write held valid across a clear: nothing lands until the first idle cycle
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        drive(1'b1, 4'd2, 32'h00000077, 4'hF);
        rd_addr_a = 4'd2;
        rd_addr_b = 4'd0;
        busy_cnt  = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cnt++;
            check($sformatf("hold_c%0d_reg2", c), rd_data_a, 32'h0);
        end
        check("hold_busy_cycles", 32'(busy_cnt), 32'd16);
        check("hold_idle_wr_ready", 32'(wr_ready), 32'd1);
        check("hold_idle_bypass", rd_data_a, 32'h00000077);
        tick();
        drive(1'b0, 4'd0, 32'h0, 4'h0);
        @(negedge clk);
        check("hold_committed_reg2", rd_data_a, 32'h00000077);
        tick();

        // Reset asserted in busy cycle 4
        drive(1'b1, 4'd4, 32'h00001234, 4'hF);
        tick();
        drive(1'b1, 4'd12, 32'h0000ABCD, 4'hF);
        tick();
        drive(1'b0, 4'd0, 32'h0, 4'h0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rstclr_c4_busy", 32'(busy), 32'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstclr_busy", 32'(busy), 32'd0);
        check("rstclr_wr_ready", 32'(wr_ready), 32'd1);
        check_all_zero("rstclr_rd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
